// File: rtl/morse_if.sv
// morse_if: character-in / key-out bundle between a character source and morse_encoder
//   char_in[7:0]      ASCII character offered by the source
//   char_valid        char_in is valid
//   char_ready        encoder can accept a character (combinational, high only when idle)
//   key_out           1 = carrier on (mark), 0 = off (space)
//   morse_signal[1:0] 01 dot / 10 dash strobe on the first cycle of each mark, else 00
//   busy              encoder is sending
//   char_err          one-cycle pulse when an accepted character has no Morse code
interface morse_if;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic       key_out;
  logic [1:0] morse_signal;
  logic       busy;
  logic       char_err;
  modport master (output char_in, char_valid, input char_ready, key_out, morse_signal, busy, char_err);
  modport slave  (input char_in, char_valid, output char_ready, key_out, morse_signal, busy, char_err);
endinterface

// File: rtl/morse_encoder.sv
// morse_encoder: plays one ASCII character per handshake as a timed Morse key waveform
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   bus          morse_if.slave: char_in/char_valid/char_ready handshake, key_out,
//                morse_signal strobes, busy and char_err status
module morse_encoder #(
  parameter int UNIT_CYCLES = 4
) (
  input logic    clk,
  input logic    rst_n,
  morse_if.slave bus
);
  localparam int CW = $clog2(7 * UNIT_CYCLES + 1);
  localparam logic [CW-1:0] L1 = CW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] L3 = CW'(3 * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] L7 = CW'(7 * UNIT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, MARK, GAP, CHGAP, WGAP} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [4:0]    pat_q, pat_d;
  logic          key_q, key_d, busy_q, busy_d, err_q, err_d;
  logic [1:0]    sig_q, sig_d;
  logic [7:0]    fold, code;
  logic [2:0]    clen;
  logic [4:0]    cpat;
  logic          cbit, nbit;
  // code = {len[2:0], pat[4:0]}, pattern right-aligned, first element at bit len-1, 1 = dash
  function automatic logic [7:0] lut(input logic [7:0] c);
    case (c)
      "A": lut = {3'd2, 5'b00001};
      "B": lut = {3'd4, 5'b01000};
      "C": lut = {3'd4, 5'b01010};
      "D": lut = {3'd3, 5'b00100};
      "E": lut = {3'd1, 5'b00000};
      "F": lut = {3'd4, 5'b00010};
      "G": lut = {3'd3, 5'b00110};
      "H": lut = {3'd4, 5'b00000};
      "I": lut = {3'd2, 5'b00000};
      "J": lut = {3'd4, 5'b00111};
      "K": lut = {3'd3, 5'b00101};
      "L": lut = {3'd4, 5'b00100};
      "M": lut = {3'd2, 5'b00011};
      "N": lut = {3'd2, 5'b00010};
      "O": lut = {3'd3, 5'b00111};
      "P": lut = {3'd4, 5'b00110};
      "Q": lut = {3'd4, 5'b01101};
      "R": lut = {3'd3, 5'b00010};
      "S": lut = {3'd3, 5'b00000};
      "T": lut = {3'd1, 5'b00001};
      "U": lut = {3'd3, 5'b00001};
      "V": lut = {3'd4, 5'b00001};
      "W": lut = {3'd3, 5'b00011};
      "X": lut = {3'd4, 5'b01001};
      "Y": lut = {3'd4, 5'b01011};
      "Z": lut = {3'd4, 5'b01100};
      "0": lut = {3'd5, 5'b11111};
      "1": lut = {3'd5, 5'b01111};
      "2": lut = {3'd5, 5'b00111};
      "3": lut = {3'd5, 5'b00011};
      "4": lut = {3'd5, 5'b00001};
      "5": lut = {3'd5, 5'b00000};
      "6": lut = {3'd5, 5'b10000};
      "7": lut = {3'd5, 5'b11000};
      "8": lut = {3'd5, 5'b11100};
      "9": lut = {3'd5, 5'b11110};
      default: lut = 8'd0;
    endcase
  endfunction
  assign fold         = (bus.char_in >= 8'h61 && bus.char_in <= 8'h7a) ? bus.char_in - 8'd32 : bus.char_in;
  assign code         = lut(fold);
  assign clen         = code[7:5];
  assign cpat         = code[4:0];
  assign cbit         = cpat[clen - 3'd1];
  assign nbit         = pat_q[idx_q - 3'd1];
  assign bus.char_ready   = state_q == IDLE;
  assign bus.key_out      = key_q;
  assign bus.morse_signal = sig_q;
  assign bus.busy         = busy_q;
  assign bus.char_err     = err_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      pat_q   <= '0;
      key_q   <= 1'b0;
      sig_q   <= 2'b00;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      key_q   <= key_d;
      sig_q   <= sig_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  // every timed state loads cnt with its length-1 on entry and leaves when it reaches 0
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - CW'(1);
    idx_d   = idx_q;
    pat_d   = pat_q;
    sig_d   = 2'b00;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = cnt_q;
        if (bus.char_valid) begin
          if (bus.char_in == 8'h20) begin
            state_d = WGAP;
            cnt_d   = L7;
          end else if (clen == 3'd0) begin
            err_d = 1'b1;
          end else begin
            state_d = MARK;
            pat_d   = cpat;
            idx_d   = clen - 3'd1;
            cnt_d   = cbit ? L3 : L1;
            sig_d   = cbit ? 2'b10 : 2'b01;
          end
        end
      end
      MARK:
        if (cnt_q == '0) begin
          state_d = (idx_q == 3'd0) ? CHGAP : GAP;
          cnt_d   = (idx_q == 3'd0) ? L3 : L1;
        end
      GAP:
        if (cnt_q == '0) begin
          state_d = MARK;
          idx_d   = idx_q - 3'd1;
          cnt_d   = nbit ? L3 : L1;
          sig_d   = nbit ? 2'b10 : 2'b01;
        end
      default:
        if (cnt_q == '0) state_d = IDLE;
    endcase
    key_d  = state_d == MARK;
    busy_d = state_d != IDLE;
  end
endmodule

// File: tb/tb_morse_encoder.sv
// tb_morse_encoder: directed-vector bench for morse_encoder at UNIT_CYCLES=4
module tb_morse_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [255:0] kv, dv, av, bv, ev;
  int rdy_at;
  logic [255:0] exp_v;
  morse_if bus ();
  morse_encoder #(.UNIT_CYCLES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // offer ch from a falling edge; returns 1 ns after the accepting rising edge (T0)
  task automatic send(input logic [7:0] ch);
    int t = 0;
    @(negedge clk);
    bus.char_in = ch;
    bus.char_valid = 1'b1;
    while (!bus.char_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.char_ready) check("ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 bus.char_valid = 1'b0;
  endtask
  // sample cycles T0+1..T0+n on falling edges; a pending valid is dropped once it is accepted
  task automatic cap(input int n);
    kv = '0; dv = '0; av = '0; bv = '0; ev = '0;
    rdy_at = -1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      kv[k] = bus.key_out;
      dv[k] = bus.morse_signal == 2'b01;
      av[k] = bus.morse_signal == 2'b10;
      bv[k] = bus.busy;
      ev[k] = bus.char_err;
      if (rdy_at < 0 && bus.char_ready) rdy_at = k;
      if (bus.char_valid && bus.char_ready) begin
        @(posedge clk);
        #1 bus.char_valid = 1'b0;
      end
    end
  endtask
  initial begin
    bus.char_in = 8'h00;
    bus.char_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_key", 64'(bus.key_out), 64'd0);
    check("rst_sig", 64'(bus.morse_signal), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_err", 64'(bus.char_err), 64'd0);
    check("rst_ready", 64'(bus.char_ready), 64'd1);
    send("E"); cap(40);
    check("E_key", kv[63:0], 64'h1E);
    check("E_dot", dv[63:0], 64'h2);
    check("E_dash", av[63:0], 64'h0);
    check("E_busy", bv[63:0], 64'h1FFFE);
    check("E_err", ev[63:0], 64'h0);
    check("E_ready", 64'(rdy_at), 64'd17);
    send("a"); cap(40);
    check("a_key", kv[63:0], 64'h1FFE1E);
    check("a_dot", dv[63:0], 64'h2);
    check("a_dash", av[63:0], 64'h200);
    check("a_ready", 64'(rdy_at), 64'd33);
    send(" "); cap(40);
    check("sp_key", kv[63:0], 64'h0);
    check("sp_busy", bv[63:0], 64'h1FFFFFFE);
    check("sp_strobe", dv[63:0] | av[63:0], 64'h0);
    check("sp_ready", 64'(rdy_at), 64'd29);
    send("#"); cap(20);
    check("hash_err", ev[63:0], 64'h2);
    check("hash_busy", bv[63:0], 64'h0);
    check("hash_key", kv[63:0], 64'h0);
    check("hash_ready", 64'(rdy_at), 64'd1);
    // '0' then '5' held pending: dashes start at 1,17,33,49,65; the last ends at 76,
    // chgap 77..88, handshake cycle 89 (ready), '5' dots start at 90,98,106,114,122
    send("0");
    bus.char_in = "5";
    bus.char_valid = 1'b1;
    cap(150);
    exp_v = '0;
    for (int i = 0; i < 5; i++) exp_v[1 + 16 * i] = 1'b1;
    check("b2b_dash_pos", av[127:64], exp_v[127:64]);
    check("b2b_dash_pos_lo", av[63:0], exp_v[63:0]);
    exp_v = '0;
    for (int i = 0; i < 5; i++) exp_v[90 + 8 * i] = 1'b1;
    check("b2b_dot_pos", dv[127:64], exp_v[127:64]);
    check("b2b_dot_lo", dv[63:0], 64'h0);
    check("b2b_chgap_low", 64'(kv[88:77]), 64'h0);
    check("b2b_chgap_busy", 64'(bv[88:77]), 64'hFFF);
    check("b2b_edges", 64'({kv[90], kv[89], kv[76]}), 64'b101);
    check("b2b_ready", 64'(rdy_at), 64'd89);
    send("Q"); cap(6);
    rst_n = 1'b0;
    #1;
    check("rstmid_key", 64'(bus.key_out), 64'd0);
    check("rstmid_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_ready", 64'(bus.char_ready), 64'd1);
    send("T"); cap(30);
    check("T_key", kv[63:0], 64'h1FFE);
    check("T_dash", av[63:0], 64'h2);
    check("T_dot", dv[63:0], 64'h0);
    check("T_ready", 64'(rdy_at), 64'd25);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
